// File: rtl/regfile_bypass.sv
// Register file with busy scoreboard, optional write-to-read forwarding
// and optional hardwired-zero register 0.
module regfile_bypass #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              Busy1,
    output logic              Busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_en;
    logic              iss_en;
    logic              hit1, hit2;
    logic              zero1, zero2;

    assign wr_en  = WriteReg && !(ZERO_REG != 0 && DstReg == '0);
    assign iss_en = IssueValid && !(ZERO_REG != 0 && IssueReg == '0);

    // Issue is applied after the clear so a new producer wins the tie.
    always_comb begin
        busy_d = busy_q;
        if (WriteReg) begin
            busy_d[DstReg] = 1'b0;
        end
        if (iss_en) begin
            busy_d[IssueReg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[DstReg] <= DstData;
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hit1  = (BYPASS != 0) && WriteReg && (DstReg == SrcReg1);
        hit2  = (BYPASS != 0) && WriteReg && (DstReg == SrcReg2);
        zero1 = (ZERO_REG != 0) && (SrcReg1 == '0);
        zero2 = (ZERO_REG != 0) && (SrcReg2 == '0);
    end

    always_comb begin
        SrcData1 = mem_q[SrcReg1];
        if (zero1) begin
            SrcData1 = '0;
        end else if (hit1) begin
            SrcData1 = DstData;
        end
    end

    always_comb begin
        SrcData2 = mem_q[SrcReg2];
        if (zero2) begin
            SrcData2 = '0;
        end else if (hit2) begin
            SrcData2 = DstData;
        end
    end

    assign Busy1 = !zero1 && !hit1 && busy_q[SrcReg1];
    assign Busy2 = !zero2 && !hit2 && busy_q[SrcReg2];

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width per register.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-007 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port: SrcReg1  input  ADDR_W  read port 1 address.
REQ-009 SHALL have port: SrcReg2  input  ADDR_W  read port 2 address.
REQ-010 SHALL have port: SrcData1  output  DATA_W  read port 1 data (driven, not tristate).
REQ-011 SHALL have port: SrcData2  output  DATA_W  read port 2 data (driven, not tristate).
REQ-012 SHALL have port: DstReg  input  ADDR_W  write address.
REQ-013 SHALL have port: WriteReg  input  1  write enable.
REQ-014 SHALL have port: DstData  input  DATA_W  write data.
REQ-015 SHALL have port: IssueValid  input  1  marks IssueReg as pending-write (busy).
REQ-016 SHALL have port: IssueReg  input  ADDR_W  register getting a new in-flight producer.
REQ-017 SHALL have port: Busy1  output  1  SrcReg1 has pending write not yet visible.
REQ-018 SHALL have port: Busy2  output  1  SrcReg2 has pending write not yet visible.

Function
REQ-019 SHALL write DstData into entry DstReg at rising clk when WriteReg=1 and rst=0.
REQ-020 SHALL provide combinational reads: SrcDataN = entry[SrcRegN] (both ports independent, same address allowed).
REQ-021 SHALL, when BYPASS=1 and WriteReg=1 and DstReg==SrcRegN, drive SrcDataN = DstData same cycle; BYPASS=0 returns old value until next cycle.
REQ-022 SHALL, when ZERO_REG=1, ignore writes to register 0 and read it as 0 regardless of bypass.
REQ-023 SHALL keep busy bit per register: set at clk when IssueValid=1 for IssueReg; cleared at clk when WriteReg=1 for DstReg.
REQ-024 SHALL, on same-cycle IssueValid and WriteReg to same register, leave busy bit set (new producer wins).
REQ-025 SHALL drive BusyN = busy[SrcRegN], except 0 when BYPASS=1 and WriteReg=1 and DstReg==SrcRegN in that cycle.
REQ-026 SHALL never set busy for register 0 when ZERO_REG=1; Busy for address 0 then reads 0.
REQ-027 SHALL treat WriteReg to a non-busy register as a normal write (busy stays 0, no error).
REQ-028 SHALL have zero-cycle read latency and one-cycle write/busy-update latency.

Reset
REQ-029 SHALL, at rising clk with rst=1, clear all entries to 0 and all busy bits to 0.
REQ-030 SHALL give rst priority over same-cycle WriteReg and IssueValid (both discarded).
REQ-031 SHALL not apply bypass during rst=1 cycle to state; outputs after the reset edge read 0, Busy 0.

Verification
REQ-032 SHALL verify: reset, then read all 16 addresses on both ports -> SrcData1/2=0x0000, Busy1/2=0.
REQ-033 SHALL verify: write R5=0xBEEF, next cycle SrcReg1=SrcReg2=5 -> both 0xBEEF; same-cycle read with BYPASS=1 -> 0xBEEF, BYPASS=0 -> 0x0000.
REQ-034 SHALL verify: IssueValid R3, next cycle SrcReg1=3 -> Busy1=1; WriteReg R3=0x1234 -> Busy1=0 same cycle (BYPASS=1), SrcData1=0x1234.
REQ-035 SHALL verify: same cycle IssueValid R7 and WriteReg R7=0x00AA -> next cycle Busy=1, SrcData=0x00AA.
REQ-036 SHALL verify: ZERO_REG=1, write R0=0xFFFF and IssueValid R0 -> SrcData=0x0000, Busy=0.
REQ-037 SHALL verify: rst=1 with WriteReg R2=0x5555 and IssueValid R2 -> after edge R2=0x0000, Busy=0; DATA_W=32/ADDR_W=5 build passes same scenarios.
